// File: rtl/jtframe_db15_pkg.sv
// Shared types and helpers for the DB15 serial joystick reader.
// Holds the scan FSM state encoding and the counter-width helper that
// sizes the bit, gap and divider counters.
package jtframe_db15_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } db15_state_e;

  // Width needed to hold the values 0..n inclusive, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jtframe_db15_cen.sv
// Tick divider for the DB15 reader: cen_o is high for one clk cycle out of
// every CLKDIV. One tick is one half-period of JOY_CLK. Free-running; it
// does not look at the scan enable.
module jtframe_db15_cen
  import jtframe_db15_pkg::*;
#(
  parameter int unsigned CLKDIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic cen_o
);

  localparam int unsigned DW = cnt_width(CLKDIV - 1);
  localparam logic [DW-1:0] LAST = DW'(CLKDIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;

  // Wrap the divider count at CLKDIV-1.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always written with <= so every register
    // samples the pre-edge values of its neighbours.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cen_o = (cnt_q == LAST);

endmodule

// File: rtl/jtframe_db15_multi.sv
// Parametrised serial joystick reader for DB15 adapters built from chained
// 74x165 shift registers. Loads the chain, clocks CHANNELS*BITS bits out of
// it, latches the frame into joystick/osd with a one-cycle valid strobe and
// then idles GAP ticks before the next load.
// Optional build macro: JTFRAME_DB15_DEBOUNCE_EN -- each output bit only
// follows the pins once two consecutive frames agree on it.
module jtframe_db15_multi
  import jtframe_db15_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned BITS     = 16,
  parameter int unsigned CLKDIV   = 8,
  parameter int unsigned GAP      = 64,
  parameter bit          INVERT   = 1'b1,
  parameter logic [15:0] OSD_MASK = 16'h0440
) (
  input  logic                       clk_sys,
  input  logic                       rst_n,
  input  logic                       enable,
  output logic                       JOY_CLK,
  output logic                       JOY_LOAD,
  input  logic                       JOY_DATA,
  output logic [CHANNELS*BITS-1:0]   joystick,
  output logic                       valid,
  output logic                       osd
);

  localparam int unsigned N  = CHANNELS * BITS;
  localparam int unsigned BW = cnt_width(N);
  localparam int unsigned GW = cnt_width(GAP);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP);
  localparam logic [BITS-1:0] OSD_M  = BITS'(OSD_MASK);

  logic cen;

  db15_state_e   state_q, state_d;
  logic [GW-1:0] gap_q,   gap_d;
  logic [BW-1:0] bit_q,   bit_d;
  logic          phase_q, phase_d;   // 0: sampling half, 1: falling half
  logic [N-1:0]  sr_q,    sr_d;
  logic          jclk_q,  jclk_d;
  logic          jload_q, jload_d;
  logic [N-1:0]  joy_q,   joy_d;
  logic          osd_q,   osd_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  frame_new;

`ifdef JTFRAME_DB15_DEBOUNCE_EN
  logic [N-1:0]  prev_q,  prev_d;    // previous raw (pin-level) frame
  logic [N-1:0]  agree;
  assign agree = ~(sr_q ^ prev_q);
`endif

  jtframe_db15_cen #(
    .CLKDIV (CLKDIV)
  ) u_cen (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .cen_o (cen)
  );

  // Pin polarity folded in before the frame reaches the outputs.
  assign frame_new = INVERT ? ~sr_q : sr_q;

  // Scan FSM next-state: advances only on the divider tick.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    sr_d    = sr_q;
    jclk_d  = jclk_q;
    jload_d = jload_q;
    joy_d   = joy_q;
    osd_d   = osd_q;
    valid_d = 1'b0;
`ifdef JTFRAME_DB15_DEBOUNCE_EN
    prev_d  = prev_q;
`endif
    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          jclk_d  = 1'b0;
          jload_d = 1'b1;
          if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
          // The GAP-th idle tick (or any later one once saturated) starts a load.
          if (enable && (int'(gap_q) + 1 >= int'(GAP))) begin
            state_d = ST_LOAD;
            jload_d = 1'b0;
          end
        end
        ST_LOAD: begin
          jload_d = 1'b1;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!phase_q) begin
            // First sampled bit ends up in bit 0 after N right shifts.
            sr_d    = {JOY_DATA, sr_q[N-1:1]};
            jclk_d  = 1'b1;
            phase_d = 1'b1;
          end else begin
            jclk_d  = 1'b0;
            phase_d = 1'b0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_d = ST_LATCH;
          end
        end
        ST_LATCH: begin
`ifdef JTFRAME_DB15_DEBOUNCE_EN
          joy_d  = (joy_q & ~agree) | (frame_new & agree);
          prev_d = sr_q;
`else
          joy_d  = frame_new;
`endif
          osd_d   = &(joy_d[BITS-1:0] | ~OSD_M);
          valid_d = 1'b1;
          gap_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Scan state and output registers; reset drops outputs immediately.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      sr_q    <= '0;
      jclk_q  <= 1'b0;
      jload_q <= 1'b1;
      joy_q   <= '0;
      osd_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      sr_q    <= sr_d;
      jclk_q  <= jclk_d;
      jload_q <= jload_d;
      joy_q   <= joy_d;
      osd_q   <= osd_d;
      valid_q <= valid_d;
    end
  end

`ifdef JTFRAME_DB15_DEBOUNCE_EN
  // History of the last raw frame for the two-frame agreement filter.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= prev_d;
  end
`endif

  assign JOY_CLK  = jclk_q;
  assign JOY_LOAD = jload_q;
  assign joystick = joy_q;
  assign valid    = valid_q;
  assign osd      = osd_q;

endmodule
